// File: rtl/exu_div_seq_pkg.sv
// Shared definitions for the EXU divide sequencer: op codes, FSM states,
// iteration counts and the divide-op decoder.
package exu_div_seq_pkg;

  localparam int EXU_OPT_WIDTH = 6;

  localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIV   = 6'd24;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVU  = 6'd25;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_REM   = 6'd26;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMU  = 6'd27;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVW  = 6'd28;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVUW = 6'd29;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMW  = 6'd30;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMUW = 6'd31;

  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
    logic is_rem;
    logic is_w;
  } div_op_t;

  function automatic div_op_t decode_div_op(input logic [EXU_OPT_WIDTH-1:0] opt);
    div_op_t d;
    d = '0;
    case (opt)
      EXU_DIV:   d = '{1'b1, 1'b1, 1'b0, 1'b0};
      EXU_DIVU:  d = '{1'b1, 1'b0, 1'b0, 1'b0};
      EXU_REM:   d = '{1'b1, 1'b1, 1'b1, 1'b0};
      EXU_REMU:  d = '{1'b1, 1'b0, 1'b1, 1'b0};
      EXU_DIVW:  d = '{1'b1, 1'b1, 1'b0, 1'b1};
      EXU_DIVUW: d = '{1'b1, 1'b0, 1'b0, 1'b1};
      EXU_REMW:  d = '{1'b1, 1'b1, 1'b1, 1'b1};
      EXU_REMUW: d = '{1'b1, 1'b0, 1'b1, 1'b1};
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exu_div_seq_div_step.sv
// One restoring-division step: shift {rem,quo} left by one and subtract the
// divisor when it fits, recording the outcome in the quotient LSB.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] rem_sh;
  logic [W:0] diff;

  assign rem_sh = {rem_i, quo_i[W-1]};
  assign diff   = rem_sh - {1'b0, dvs_i};

  // rem < divisor always holds, so a non-negative difference fits in W bits
  // and bit W of the difference is a clean borrow flag.
  always_comb begin
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exu_div_seq.sv
// Multi-cycle RV64M divide/remainder unit: operand prep, one-bit-per-cycle
// restoring divide, sign fix-up and valid/ready handshakes on both sides.
module exu_div_seq
  import exu_div_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [EXU_OPT_WIDTH-1:0] i_exopt,
  input  logic [XLEN-1:0]          i_src1,
  input  logic [XLEN-1:0]          i_src2,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_result
);

  localparam logic [XLEN-1:0]  XMIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] ITER_D = CNT_W'(DIV_ITER_D);
  localparam logic [CNT_W-1:0] ITER_W = CNT_W'(DIV_ITER_W);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             is_rem_q, is_rem_d;
  logic             is_w_q, is_w_d;

  div_op_t          op;
  logic [XLEN-1:0]  src1_ext, src2_ext, src1_mag, src2_mag, quo_init;
  logic [XLEN-1:0]  spc_quo, spc_rem;
  logic             sign1, sign2, div_zero, ovf, accept;
  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN-1:0]  fix_quo, fix_rem, fix_sel, fix_res;
  logic [CNT_W-1:0] iter_n;

  assign op       = decode_div_op(i_exopt);
  assign o_ready  = (state_q == DIV_IDLE) & ~i_flush;
  assign accept   = i_valid & o_ready & op.is_div;
  assign o_valid  = (state_q == DIV_DONE);
  assign o_result = res_q;
  assign iter_n   = is_w_q ? ITER_W : ITER_D;

  always_comb begin
    if (op.is_w) begin
      src1_ext = op.is_signed ? sext32(i_src1[31:0]) : {{(XLEN-32){1'b0}}, i_src1[31:0]};
      src2_ext = op.is_signed ? sext32(i_src2[31:0]) : {{(XLEN-32){1'b0}}, i_src2[31:0]};
    end else begin
      src1_ext = i_src1;
      src2_ext = i_src2;
    end
    sign1    = op.is_signed & src1_ext[XLEN-1];
    sign2    = op.is_signed & src2_ext[XLEN-1];
    src1_mag = sign1 ? -src1_ext : src1_ext;
    src2_mag = sign2 ? -src2_ext : src2_ext;
    // W dividends sit in the upper half so 32 steps leave the quotient in [31:0].
    quo_init = op.is_w ? (src1_mag << 32) : src1_mag;
    div_zero = (src2_ext == '0);
    ovf      = op.is_signed & (src1_ext == (op.is_w ? sext32(32'h8000_0000) : XMIN))
               & (&src2_ext);
    spc_quo  = div_zero ? '1 : (op.is_w ? sext32(32'h8000_0000) : XMIN);
    spc_rem  = div_zero ? (op.is_w ? sext32(i_src1[31:0]) : i_src1) : '0;
  end

  div_step #(.W(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    fix_quo = q_neg_q ? -step_quo : step_quo;
    fix_rem = r_neg_q ? -step_rem : step_rem;
    fix_sel = is_rem_q ? fix_rem : fix_quo;
    fix_res = is_w_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    is_w_d   = is_w_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          q_neg_d  = sign1 ^ sign2;
          r_neg_d  = sign1;
          is_rem_d = op.is_rem;
          is_w_d   = op.is_w;
          if (div_zero | ovf) begin
            state_d = DIV_DONE;
            res_d   = op.is_rem ? spc_rem : spc_quo;
          end else begin
            state_d = DIV_CALC;
            rem_d   = '0;
            quo_d   = quo_init;
            dvs_d   = src2_mag;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == iter_n) begin
          state_d = DIV_DONE;
          res_d   = fix_res;
        end
      end
      DIV_DONE: begin
        if (i_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    // Flush beats everything, including a same-cycle consume.
    if (i_flush) begin
      state_d = DIV_IDLE;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      is_w_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      is_w_q   <= is_w_d;
    end
  end

endmodule

// File: tb/tb_exu_div_seq.sv
// Self-checking bench for exu_div_seq: directed vectors, randomized ops
// against an arithmetic reference, handshake/flush/reset corner cases.
module tb_exu_div_seq;
  import exu_div_seq_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic [EXU_OPT_WIDTH-1:0] i_exopt = '0;
  logic [63:0]              i_src1 = '0;
  logic [63:0]              i_src2 = '0;
  logic                     i_flush = 1'b0;
  logic                     o_valid;
  logic                     i_ready = 1'b0;
  logic [63:0]              o_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exu_div_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_exopt  (i_exopt),
    .i_src1   (i_src1),
    .i_src2   (i_src2),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic op_signed(input logic [EXU_OPT_WIDTH-1:0] op);
    return (op == EXU_DIV) || (op == EXU_REM) || (op == EXU_DIVW) || (op == EXU_REMW);
  endfunction
  function automatic logic op_rem(input logic [EXU_OPT_WIDTH-1:0] op);
    return (op == EXU_REM) || (op == EXU_REMU) || (op == EXU_REMW) || (op == EXU_REMUW);
  endfunction
  function automatic logic op_w(input logic [EXU_OPT_WIDTH-1:0] op);
    return (op == EXU_DIVW) || (op == EXU_DIVUW) || (op == EXU_REMW) || (op == EXU_REMUW);
  endfunction

  function automatic logic is_special(input logic [EXU_OPT_WIDTH-1:0] op, input logic [63:0] a, b);
    if (op_w(op))
      return (b[31:0] == 32'd0) ||
             (op_signed(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) ||
           (op_signed(op) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic int ref_latency(input logic [EXU_OPT_WIDTH-1:0] op, input logic [63:0] a, b);
    if (is_special(op, a, b)) return 1;
    return op_w(op) ? 33 : 65;
  endfunction

  function automatic logic [63:0] ref_result(input logic [EXU_OPT_WIDTH-1:0] op, input logic [63:0] a, b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic        [63:0] r;
    logic        [31:0] r32;
    if (op_w(op)) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0)     r32 = op_rem(op) ? a[31:0] : 32'hFFFF_FFFF;
      else if (is_special(op, a, b)) r32 = op_rem(op) ? 32'd0 : 32'h8000_0000;
      else if (op_signed(op))   r32 = op_rem(op) ? sa32 % sb32 : sa32 / sb32;
      else                      r32 = op_rem(op) ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      return {{32{r32[31]}}, r32};
    end
    sa = a;
    sb = b;
    if (b == 64'd0)                r = op_rem(op) ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (is_special(op, a, b)) r = op_rem(op) ? 64'd0 : 64'h8000_0000_0000_0000;
    else if (op_signed(op))        r = op_rem(op) ? sa % sb : sa / sb;
    else                           r = op_rem(op) ? a % b : a / b;
    return r;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 20));
      2: return 64'd0;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return ($urandom_range(0, 1) == 1) ? 64'h8000_0000_0000_0000 : {$urandom, 32'h8000_0000};
      default: return -64'($urandom_range(1, 100));
    endcase
  endfunction

  // Issue one op, scramble the inputs after accept, wait for the result, consume it.
  task automatic run_op(input logic [EXU_OPT_WIDTH-1:0] op, input logic [63:0] a, b,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_exopt = op; i_src1 = a; i_src2 = b;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_exopt = EXU_DIV + EXU_OPT_WIDTH'($urandom_range(0, 7));
    i_src1  = {$urandom, $urandom};
    i_src2  = {$urandom, $urandom};
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = o_result;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h, required ready=1 valid=0 result=0",
               o_ready, o_valid, o_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [EXU_OPT_WIDTH-1:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        v[12];
    logic [63:0] res;
    int          lat;
    v[0]  = '{EXU_DIVU,  64'd100, 64'd7, 64'd14, 65};
    v[1]  = '{EXU_REMU,  64'd100, 64'd7, 64'd2, 65};
    v[2]  = '{EXU_DIV,   -64'd7, 64'd2, -64'd3, 65};
    v[3]  = '{EXU_REM,   -64'd7, 64'd2, -64'd1, 65};
    v[4]  = '{EXU_DIVW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    v[5]  = '{EXU_REMW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    v[6]  = '{EXU_DIV,   64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[7]  = '{EXU_REMUW, 64'hFFFF_FFFF_0000_0005, 64'd0, 64'd5, 1};
    v[8]  = '{EXU_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    v[9]  = '{EXU_DIV,   64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, 1};
    v[10] = '{EXU_REM,   64'h8000_0000_0000_0000, -64'd1, 64'd0, 1};
    v[11] = '{EXU_REMW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, lat);
      n_checks++;
      if (res !== v[i].exp) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, res, v[i].exp);
      end
      n_checks++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_backpressure_back_to_back();
    int lat;
    @(negedge clk);
    i_valid = 1'b1; i_exopt = EXU_DIVU; i_src1 = 64'd1000; i_src2 = 64'd3;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 64'd333) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: valid=%b ready=%b result=%h, required valid=1 ready=0 result=%h",
                 k, o_valid, o_ready, o_result, 64'd333);
      end
      i_src1 = {$urandom, $urandom};
      @(negedge clk);
    end
    // Consume and present a new request in the same cycle: must not be accepted yet.
    i_ready = 1'b1; i_valid = 1'b1; i_exopt = EXU_DIVW; i_src1 = -64'd100; i_src2 = 64'd7;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL consume_cycle_no_accept: valid=%b ready=%b, required valid=0 ready=1", o_valid, o_ready);
    end
    i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 33 || o_result !== 64'hFFFF_FFFF_FFFF_FFF2) begin
      n_fail++;
      $display("FAIL back_to_back: latency %0d result %h, required latency 33 result %h",
               lat, o_result, 64'hFFFF_FFFF_FFFF_FFF2);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic        seen;
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    i_valid = 1'b1; i_exopt = EXU_DIVU; i_src1 = 64'hFFFF_0000_1234_5678; i_src2 = 64'd13;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (19) @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_calc_outputs: ready=%b valid=%b, required ready=0 valid=0", o_ready, o_valid);
    end
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_to_idle: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
    end
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: o_valid rose=%b, required 0", seen);
    end
    run_op(EXU_DIVU, 64'd9, 64'd3, res, lat);
    n_checks++;
    if (res !== 64'd3 || lat !== 65) begin
      n_fail++;
      $display("FAIL after_flush_op: result %h latency %0d, required 3 latency 65", res, lat);
    end
  endtask

  task automatic test_flush_corners();
    int lat;
    @(negedge clk);
    i_valid = 1'b1; i_exopt = EXU_DIV; i_src1 = 64'd50; i_src2 = 64'd0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    i_flush = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_ready = 1'b0;
    #1;
    n_checks++;
    if (lat !== 1 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_with_ready: latency %0d valid=%b ready=%b, required latency 1 valid=0 ready=1",
               lat, o_valid, o_ready);
    end
    i_valid = 1'b1; i_flush = 1'b1; i_exopt = EXU_DIVU; i_src1 = 64'd77; i_src2 = 64'd5;
    #1;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_ready: ready=%b, required 0", o_ready);
    end
    @(negedge clk);
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_valid: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
    end
    i_valid = 1'b1; i_exopt = 6'd3; i_src2 = 64'd0;
    repeat (3) @(negedge clk);
    i_valid = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL non_div_ignored: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat;
    run_op(EXU_REMU, 64'd1001, 64'd10, res, lat);
    @(negedge clk);
    i_valid = 1'b1; i_exopt = EXU_DIVU; i_src1 = 64'd123456; i_src2 = 64'd11;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b valid=%b result=%h, required ready=1 valid=0 result=0",
               o_ready, o_valid, o_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [EXU_OPT_WIDTH-1:0] op;
    logic [63:0]              a, b, res, exp;
    int                       lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = EXU_DIV + EXU_OPT_WIDTH'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      exp     = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      run_op(op, a, b, res, lat);
      n_checks++;
      if (res !== exp || lat !== exp_lat) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: result %h latency %0d, required %h latency %0d",
                 i, op, a, b, res, lat, exp, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure_back_to_back();
    test_flush();
    test_flush_corners();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
